// File: rtl/tx_msg_composer.sv
// tx_msg_composer: builds a text status frame (mode name + decimal rate)
// and streams it byte by byte to a UART over a valid/ready handshake.
// Ports:
//   clk, reset (sync, active-low)
//   iSTART, iMODE, iRATE, iABORT : frame request, captured fields, cancel
//   iTX_READY                    : UART can accept a byte
//   oTX_DATA, oTX_VALID          : registered byte offer (0xFF when idle)
//   oBUSY, oDONE                 : frame in progress / completion pulse
module tx_msg_composer #(
  parameter int RATE_W      = 8,
  parameter int RATE_DIGITS = 3,
  parameter int MODE_W      = 2,
  parameter int NAME_LEN    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iSTART,
  input  logic [MODE_W-1:0] iMODE,
  input  logic [RATE_W-1:0] iRATE,
  input  logic              iABORT,
  input  logic              iTX_READY,
  output logic [7:0]        oTX_DATA,
  output logic              oTX_VALID,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int FRAME_LEN = 22 + NAME_LEN + RATE_DIGITS;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int CNT_W     = $clog2(RATE_W + 1);
  localparam int BCD_W     = 4 * RATE_DIGITS;
  localparam int RC_W      = 8 * RATE_DIGITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATE_W - 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned v;
    v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v;
  endfunction

  localparam longint unsigned RATE_MAX = pow10(RATE_DIGITS) - 1;

  function automatic logic [7:0] frameByte(
    input int              i,
    input logic [MODE_W-1:0] m,
    input logic [RC_W-1:0] rc
  );
    logic [8*14-1:0] head;
    logic [8*7-1:0]  rt;
    logic [8*7-1:0]  name;
    int              p;
    head = "current state:";
    rt   = "  rate:";
    case (int'(m))
      0:       name = "control";
      1:       name = "initial";
      2:       name = "normal ";
      3:       name = "error  ";
      default: name = "unknown";
    endcase
    frameByte = 8'h0A;
    if (i < 14) begin
      frameByte = head[8*(13-i) +: 8];
    end else if (i < 14 + NAME_LEN) begin
      p = i - 14;
      frameByte = (p < 7) ? name[8*(6-p) +: 8] : 8'h20;
    end else if (i < 21 + NAME_LEN) begin
      p = i - 14 - NAME_LEN;
      frameByte = rt[8*(6-p) +: 8];
    end else if (i < 21 + NAME_LEN + RATE_DIGITS) begin
      p = i - 21 - NAME_LEN;
      frameByte = rc[8*(RATE_DIGITS-1-p) +: 8];
    end
  endfunction

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [BCD_W-1:0]  bcd;
  logic [RATE_W-1:0] shReg;
  logic [MODE_W-1:0] modeReg;
  logic              ovf;
  logic [7:0]        txData;
  logic              txValid;
  logic              done;

  logic [BCD_W-1:0]  adj;
  logic [RC_W-1:0]   rateChars;
  logic [7:0]        nextByte;

  // add-3 correction before each shift; digits above RATE_DIGITS are
  // not kept, out-of-range rates are replaced by all nines anyway
  always_comb begin
    adj = bcd;
    for (int d = 0; d < RATE_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // leading zeros blank to space, the units digit always prints
  always_comb begin : rc_blk
    logic       lead;
    logic [3:0] dig;
    rateChars = '0;
    lead      = 1'b1;
    dig       = '0;
    for (int d = RATE_DIGITS - 1; d >= 0; d--) begin
      dig = bcd[4*d +: 4];
      if (ovf) begin
        rateChars[8*d +: 8] = 8'h39;
      end else if (lead && dig == 4'd0 && d != 0) begin
        rateChars[8*d +: 8] = 8'h20;
      end else begin
        rateChars[8*d +: 8] = {4'h3, dig};
        lead = 1'b0;
      end
    end
  end

  assign nextByte = frameByte(int'(idx) + 1, modeReg, rateChars);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      bcd     <= '0;
      shReg   <= '0;
      modeReg <= '0;
      ovf     <= 1'b0;
      txData  <= 8'hFF;
      txValid <= 1'b0;
      done    <= 1'b0;
    end else if (iABORT) begin
      state   <= IDLE;
      idx     <= '0;
      txData  <= 8'hFF;
      txValid <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iSTART) begin
            modeReg <= iMODE;
            shReg   <= iRATE;
            ovf     <= 64'(iRATE) > RATE_MAX;
            bcd     <= '0;
            cnt     <= '0;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd   <= {adj[BCD_W-2:0], shReg[RATE_W-1]};
          shReg <= shReg << 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state   <= SEND;
            idx     <= '0;
            txValid <= 1'b1;
            txData  <= frameByte(0, modeReg, rateChars);
          end
        end
        SEND: begin
          if (iTX_READY) begin
            if (idx == LAST_IDX) begin
              state   <= IDLE;
              idx     <= '0;
              txValid <= 1'b0;
              txData  <= 8'hFF;
              done    <= 1'b1;
            end else begin
              idx    <= idx + IDX_W'(1);
              txData <= nextByte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oTX_DATA  = txData;
  assign oTX_VALID = txValid;
  assign oBUSY     = (state != IDLE);
  assign oDONE     = done;

endmodule

// File: tb/tb_tx_msg_composer.sv
// Bench for tx_msg_composer: two instances (RATE_W 8 and 12) share stimulus
// and are checked every cycle against a frame-level model.
module tb_tx_msg_composer;

  logic        clk = 1'b0;
  logic        reset, iSTART, iABORT, iTX_READY;
  logic [1:0]  iMODE;
  logic [11:0] rate;
  logic [7:0]  dA, dB;
  logic        vA, vB, bA, bB, doA, doB;

  always #5 clk = ~clk;

  tx_msg_composer dutA (
    .clk(clk), .reset(reset), .iSTART(iSTART), .iMODE(iMODE),
    .iRATE(rate[7:0]), .iABORT(iABORT), .iTX_READY(iTX_READY),
    .oTX_DATA(dA), .oTX_VALID(vA), .oBUSY(bA), .oDONE(doA)
  );

  tx_msg_composer #(.RATE_W(12)) dutB (
    .clk(clk), .reset(reset), .iSTART(iSTART), .iMODE(iMODE),
    .iRATE(rate), .iABORT(iABORT), .iTX_READY(iTX_READY),
    .oTX_DATA(dB), .oTX_VALID(vB), .oBUSY(bB), .oDONE(doB)
  );

  int tests = 0;
  int fails = 0;

  int         ph [2];
  int         cl [2];
  int         ptr[2];
  int         len[2];
  logic [7:0] fr [2][64];
  bit         mdone[2];
  string      got[2];
  int         hs [2];
  logic       lastV[2];
  logic [7:0] lastD[2];
  bit         rndRdy = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkStr(input string nm, input string act, input string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    end
  endtask

  function automatic string mkFrame(input int mode, input int r);
    string nm, rs;
    case (mode)
      0: nm = "control";
      1: nm = "initial";
      2: nm = "normal";
      3: nm = "error";
      default: nm = "unknown";
    endcase
    while (nm.len() < 8) nm = {nm, " "};
    if (r > 999) rs = "999";
    else rs = $sformatf("%3d", r);
    return {"current state:", nm, "  rate:", rs, "\n"};
  endfunction

  function automatic int rw(input int k);
    return (k == 0) ? 8 : 12;
  endfunction

  task automatic step(input int k);
    string s;
    if (!reset || iABORT) begin
      ph[k]    = 0;
      mdone[k] = 0;
    end else begin
      if (lastV[k] && iTX_READY) begin
        got[k] = {got[k], $sformatf("%c", lastD[k])};
        hs[k]++;
      end
      mdone[k] = 0;
      case (ph[k])
        0: if (iSTART) begin
          s = mkFrame(int'(iMODE), int'(rate) & ((1 << rw(k)) - 1));
          len[k] = s.len();
          for (int i = 0; i < s.len(); i++) fr[k][i] = s[i];
          cl[k]  = rw(k);
          ph[k]  = 1;
          got[k] = "";
          hs[k]  = 0;
        end
        1: begin
          cl[k]--;
          if (cl[k] == 0) begin
            ph[k]  = 2;
            ptr[k] = 0;
          end
        end
        default: if (iTX_READY) begin
          ptr[k]++;
          if (ptr[k] == len[k]) begin
            ph[k]    = 0;
            mdone[k] = 1;
          end
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    step(0);
    step(1);
  end

  logic [10:0] ca, ce;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ca = (k == 0) ? {vA, bA, doA, dA} : {vB, bB, doB, dB};
      ce = {ph[k] == 2, ph[k] != 0, mdone[k],
            (ph[k] == 2) ? fr[k][ptr[k]] : 8'hFF};
      lastV[k] = ca[10];
      lastD[k] = ca[7:0];
      chk((k == 0) ? "cycleA" : "cycleB", 32'(ca), 32'(ce));
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rndRdy) iTX_READY = 1'($urandom_range(0, 1));
  endtask

  task automatic startFrame(input int m, input int r);
    iMODE  = 2'(m);
    rate   = 12'(r);
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((ph[0] != 0 || ph[1] != 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      tests++;
      fails++;
      $display("FAIL timeout: frame not finished after %0d cycles", n);
    end
  endtask

  initial begin
    int nA, nB, n, abAt;
    reset = 1'b0; iSTART = 1'b0; iABORT = 1'b0; iTX_READY = 1'b0;
    iMODE = '0; rate = '0;
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; mdone[k] = 0; hs[k] = 0; got[k] = "";
      lastV[k] = 0; lastD[k] = 8'hFF;
    end
    repeat (3) tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("idleValid", 32'(vA), 0);
    chk("idleData", 32'(dA), 32'hFF);

    chkStr("modelPin", mkFrame(2, 50), "current state:normal    rate: 50\n");
    chkStr("modelPin0", mkFrame(1, 0), "current state:initial   rate:  0\n");

    // defaults frame, latency, no bubbles
    iTX_READY = 1'b1;
    startFrame(2, 50);
    nA = 0; nB = 0; n = 1;
    while ((nA == 0 || nB == 0) && n < 40) begin
      if (vA && nA == 0) nA = n;
      if (vB && nB == 0) nB = n;
      if (nA == 0 || nB == 0) begin
        tick();
        n++;
      end
    end
    chk("latencyA", 32'(nA), 9);
    chk("latencyB", 32'(nB), 13);
    waitIdle();
    chkStr("frameA50", got[0], "current state:normal    rate: 50\n");
    chk("doneB", 32'(doB), 1);

    // start in B's done cycle; random ready; inputs change after capture
    rndRdy = 1;
    startFrame(1, 200);
    chk("startInDone", 32'(bB), 1);
    iMODE = 2'd0;
    rate  = 12'd5;
    waitIdle();
    chkStr("frameA200", got[0], "current state:initial   rate:200\n");
    chkStr("frameB200", got[1], "current state:initial   rate:200\n");

    // abort after the 10th handshake
    rndRdy = 0;
    iTX_READY = 1'b1;
    startFrame(0, 7);
    n = 0;
    while (hs[0] < 10 && n < 100) begin
      tick();
      n++;
    end
    chk("hsReached", 32'(hs[0]), 10);
    iABORT = 1'b1;
    tick();
    iABORT = 1'b0;
    chk("abortValid", 32'(vA), 0);
    chk("abortData", 32'(dA), 32'hFF);
    chk("abortDone", 32'(doA), 0);
    tick();
    startFrame(0, 7);
    waitIdle();
    chkStr("frameAfterAbort", got[0], "current state:control   rate:  7\n");

    // overflow and zero on both widths
    startFrame(3, 1500);
    waitIdle();
    chkStr("ovfB", got[1], "current state:error     rate:999\n");
    chkStr("wrapA", got[0], "current state:error     rate:220\n");
    startFrame(1, 0);
    waitIdle();
    chkStr("zeroB", got[1], "current state:initial   rate:  0\n");

    // start pulses during SEND, then reset during byte 20
    startFrame(2, 123);
    n = 0;
    while (hs[0] < 20 && n < 100) begin
      iSTART = (ph[0] == 2) ? ~iSTART : 1'b0;
      tick();
      n++;
    end
    iSTART = 1'b0;
    reset  = 1'b0;
    tick();
    chk("rstValid", 32'(vA), 0);
    chk("rstData", 32'(dA), 32'hFF);
    chk("rstBusy", 32'(bA), 0);
    chk("rstDone", 32'(doA), 0);
    reset = 1'b1;
    tick();
    startFrame(2, 123);
    waitIdle();
    chkStr("frameAfterRst", got[0], "current state:normal    rate:123\n");

    // random frames with occasional aborts
    rndRdy = 1;
    for (int it = 0; it < 10; it++) begin
      abAt = (it % 3 == 0) ? int'($urandom_range(0, 60)) : -1;
      startFrame(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
      for (int c = 0; c < 400; c++) begin
        if (ph[0] == 0 && ph[1] == 0) break;
        if (c == abAt) begin
          iABORT = 1'b1;
          tick();
          iABORT = 1'b0;
        end else begin
          tick();
        end
      end
      waitIdle();
    end
    rndRdy = 0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
